rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-way resource among 8 requesters.
- Selects one requester using rotating priority, encodes it to a 3-bit index and holds the grant until the owner releases it.
- Sits in front of the shared resource that today is addressed by a priority-encoded 3-bit index.
- Adds fairness, grant locking and an enable gate to that index.

Parameters:
- NREQ, 8, number of requesters; fixed at 8 so the index is 3 bits.
- MAX_HOLD, 16, maximum grant duration in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; when low, no new grant is issued
- req  input  8  request vector, bit i = requester i; level-sensitive
- done  input  1  single-cycle release pulse from the current owner
- gnt  output  8  one-hot grant, registered
- gnt_idx  output  3  binary index of the granted requester, registered
- gnt_vld  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse when a grant is revoked; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, rst_n low):
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - State=IDLE, pointer ptr=0, hold counter=0.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_vld equals |gnt.
  - gnt_idx equals the encoded gnt when gnt_vld=1; otherwise gnt_idx holds its last value.
- Selection (combinational):
  - Rotate req right by ptr, priority-encode the lowest set bit, add ptr modulo 8.
  - Result: the first requesting index at or after ptr, wrapping 7->0.
- IDLE state:
  - If en=1 and req!=0, register the selected grant: next cycle gnt_vld=1, state=GRANT.
  - Latency is 1 cycle from req to gnt.
  - If en=0 or req=0, stay in IDLE with outputs unchanged.
- GRANT state:
  - The grant is held regardless of other req bits.
  - Release occurs when done=1, or when req[gnt_idx]=0 (owner dropped its request).
  - On release, set ptr = gnt_idx+1 (mod 8).
  - In the same edge, if en=1 and another requester is active, register the next grant immediately (back-to-back, no bubble).
  - The next grant is selected from the updated ptr, so the releasing owner has the lowest priority. If it alone still requests, it is re-granted.
  - If nothing is requesting or en=0 at release, clear gnt and return to IDLE.
- done while in IDLE: ignored.
- en dropping during GRANT: does not revoke the current grant; it only blocks the next one.
- Simultaneous done and timeout on the same edge: treated as a normal release, timeout=0.
- Reset during GRANT: grant removed immediately (asynchronous); ptr restarts at 0.
- Fairness: with all 8 requesters held active and each releasing after k cycles, grant order is 0,1,...,7,0,...

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - If the counter reaches MAX_HOLD-1 without a release, the grant is revoked as a release (ptr advances past the owner) and timeout pulses for 1 cycle on the gnt change.
  - The next grant follows the normal back-to-back rules.
- Without the macro:
  - No counter logic is built.
  - timeout is tied to 0.
  - A grant is held indefinitely until done or the owner's req drops.

Test Plan:
- Reset with req=8'hFF -> gnt=0, gnt_vld=0. After rst_n rises with en=1: cycle 1 gnt=8'h01, gnt_idx=0.
- req=8'hFF held, done pulsed every 3 cycles -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, with no idle cycle between grants.
- Owner idx 2 granted, then req=8'b0010_0100 and done -> next gnt_idx=5. If only req[2]=1 at done -> gnt_idx=2 re-granted.
- During the grant to idx 3, drop en, then pulse done with req=8'h81 -> gnt=0, gnt_vld=0. Raise en -> gnt_idx=7 one cycle later (ptr=4).
- Owner drops req[gnt_idx] without done -> grant released on that edge, ptr advances; with req=0, gnt_vld=0 the next cycle.
- ARB_TIMEOUT_EN with MAX_HOLD=4, req=8'h03, no done -> gnt_idx 0 for 4 cycles, timeout pulses, gnt_idx=1. Without the macro, gnt_idx stays 0 and timeout stays 0 for 100 cycles.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters, registered one-hot grant plus 3-bit index, grant locked until release.
// Optional macro ARB_TIMEOUT_EN revokes a grant held MAX_HOLD cycles and pulses timeout.
module rr_arbiter8 #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            timeout_q, timeout_d;
  logic            hold_hit;
  logic            release_c;
  logic [2:0]      pick_ptr;
  logic [2:0]      pick_idx;

  // First requester at or after p, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    dbl = {r, r};
    rot = dbl[p +: 8];
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = i[2:0];
    end
    return p + off;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;

  assign hold_hit = (hold_q == HW'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == GRANT) hold_d = hold_q + 1'b1;
    if (gnt_d != 0 && (state_q == IDLE || release_c)) hold_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_hit = 1'b0;
`endif

  assign release_c = (state_q == GRANT) && (done || !req[idx_q] || hold_hit);
  assign pick_ptr  = release_c ? idx_q + 3'd1 : ptr_q;
  assign pick_idx  = rr_pick(req, pick_ptr);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && req != 0) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d     = pick_ptr;
          // A timeout coinciding with any ordinary release is just a release.
          timeout_d = hold_hit && done == 1'b0 && req[idx_q];
          if (en && req != 0) begin
            idx_d = pick_idx;
            gnt_d = NREQ'(1) << pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, fairness, rotation, enable gate, owner drop, async reset, timeout.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.NREQ(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    done  = 1'b0;
    #12;
    total++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: gnt=%h vld=%b idx=%0d to=%b, want gnt=00 vld=0 idx=0 to=0",
               gnt, gnt_vld, gnt_idx, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_vld !== 1'b1) begin
      bad++;
      $display("FAIL first_grant: gnt=%h idx=%0d vld=%b, want gnt=01 idx=0 vld=1", gnt, gnt_idx, gnt_vld);
    end
  endtask

  // Continues from test_reset: owner 0 holds, all requesting, done every 3rd cycle.
  task automatic test_fairness();
    logic [2:0] exp_idx;
    exp_idx = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      for (int c = 0; c < 2; c++) begin
        done = 1'b0;
        tick();
        total++;
        if (gnt_vld !== 1'b1 || gnt_idx !== exp_idx) begin
          bad++;
          $display("FAIL fair_hold: idx=%0d vld=%b, want idx=%0d vld=1", gnt_idx, gnt_vld, exp_idx);
        end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_idx = exp_idx + 3'd1;
      total++;
      if (gnt_vld !== 1'b1 || gnt_idx !== exp_idx || gnt !== (8'h01 << exp_idx)) begin
        bad++;
        $display("FAIL fair_next: idx=%0d gnt=%h vld=%b, want idx=%0d vld=1", gnt_idx, gnt, gnt_vld, exp_idx);
      end
    end
  endtask

  task automatic test_rotate();
    do_reset();
    req = 8'h04;
    tick();
    req  = 8'b0010_0100;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin
      bad++;
      $display("FAIL rotate_skip: idx=%0d gnt=%h, want idx=5 gnt=20", gnt_idx, gnt);
    end
    do_reset();
    req = 8'h04;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt_idx !== 3'd2 || gnt_vld !== 1'b1) begin
      bad++;
      $display("FAIL rotate_regrant: idx=%0d vld=%b, want idx=2 vld=1", gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_en_gate();
    do_reset();
    req = 8'h08;
    tick();
    en = 1'b0;
    tick();
    total++;
    if (gnt_idx !== 3'd3 || gnt_vld !== 1'b1) begin
      bad++;
      $display("FAIL en_hold: idx=%0d vld=%b, want idx=3 vld=1", gnt_idx, gnt_vld);
    end
    req  = 8'h81;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd3) begin
      bad++;
      $display("FAIL en_block: gnt=%h vld=%b idx=%0d, want gnt=00 vld=0 idx=3", gnt, gnt_vld, gnt_idx);
    end
    tick();
    total++;
    if (gnt_vld !== 1'b0) begin
      bad++;
      $display("FAIL en_idle: vld=%b, want 0", gnt_vld);
    end
    en = 1'b1;
    tick();
    total++;
    if (gnt_idx !== 3'd7 || gnt !== 8'h80) begin
      bad++;
      $display("FAIL en_resume: idx=%0d gnt=%h, want idx=7 gnt=80", gnt_idx, gnt);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    total++;
    if (gnt_vld !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd1) begin
      bad++;
      $display("FAIL drop_release: gnt=%h vld=%b idx=%0d, want gnt=00 vld=0 idx=1", gnt, gnt_vld, gnt_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (gnt_vld !== 1'b0) begin
      bad++;
      $display("FAIL done_idle: vld=%b, want 0", gnt_vld);
    end
    req = 8'h06;
    tick();
    total++;
    if (gnt_idx !== 3'd2) begin
      bad++;
      $display("FAIL drop_ptr: idx=%0d, want 2", gnt_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: gnt=%h vld=%b idx=%0d, want gnt=00 vld=0 idx=0", gnt, gnt_vld, gnt_idx);
    end
    req = 8'hFF;
    #2;
    rst_n = 1'b1;
    tick();
    total++;
    if (gnt_idx !== 3'd0 || gnt_vld !== 1'b1) begin
      bad++;
      $display("FAIL reset_ptr: idx=%0d vld=%b, want idx=0 vld=1", gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h03;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (gnt_idx !== 3'd0 || timeout !== 1'b0 || gnt_vld !== 1'b1) begin
        bad++;
        $display("FAIL to_hold: cyc=%0d idx=%0d to=%b, want idx=0 to=0", c, gnt_idx, timeout);
      end
    end
    tick();
    total++;
    if (gnt_idx !== 3'd1 || timeout !== 1'b1) begin
      bad++;
      $display("FAIL to_revoke: idx=%0d to=%b, want idx=1 to=1", gnt_idx, timeout);
    end
    tick();
    total++;
    if (timeout !== 1'b0 || gnt_idx !== 3'd1) begin
      bad++;
      $display("FAIL to_pulse: idx=%0d to=%b, want idx=1 to=0", gnt_idx, timeout);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      total++;
      if (gnt_idx !== 3'd0 || timeout !== 1'b0 || gnt_vld !== 1'b1) begin
        bad++;
        $display("FAIL no_timeout: cyc=%0d idx=%0d to=%b vld=%b, want idx=0 to=0 vld=1",
                 c, gnt_idx, timeout, gnt_vld);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_rotate();
    test_en_gate();
    test_owner_drop();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
